// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: game state, direction codes and
// default screen geometry. The drawing stage imports the same package.
package snake_pkg;

   // Game state bus encoding; 2'b10 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_OVER = 2'b11
   } game_state_e;

   // Direction codes driven by the input/drawing stage.
   typedef enum logic [2:0] {
      DIR_IDLE  = 3'd0,
      DIR_UP    = 3'd1,
      DIR_DOWN  = 3'd2,
      DIR_LEFT  = 3'd3,
      DIR_RIGHT = 3'd4
   } direction_e;

   // Default visible area and wall thickness.
   localparam int H_RES_DEF  = 640;
   localparam int V_RES_DEF  = 480;
   localparam int BORDER_DEF = 5;

endpackage

// File: rtl/snake_hit_detect.sv
// Per-pixel collision and apple detection. Flags are sticky for one frame,
// include the pixel presented alongside frame_end, and clear after it.
module snake_hit_detect
   import snake_pkg::*;
#(
   parameter int BIT    = 10,
   parameter int H_RES  = H_RES_DEF,
   parameter int V_RES  = V_RES_DEF,
   parameter int BORDER = BORDER_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [BIT-1:0] x_pos,
   input  logic [BIT-1:0] y_pos,
   input  logic           frame_end,
   input  logic           enable,
   input  logic           snake_head_active,
   input  logic           snake_body_active,
   input  logic           apple_active,
   output logic           body_hit,
   output logic           wall_hit,
   output logic           apple_hit
);

   localparam logic [BIT-1:0] LO_LIM = BIT'(BORDER);
   localparam logic [BIT-1:0] X_HI   = BIT'(H_RES - BORDER);
   localparam logic [BIT-1:0] Y_HI   = BIT'(V_RES - BORDER);

   logic body_q, wall_q, apple_q;
   logic body_d, wall_d, apple_d;
   logic in_wall;
   logic head_now;

   assign in_wall  = (x_pos < LO_LIM) | (x_pos >= X_HI) |
                     (y_pos < LO_LIM) | (y_pos >= Y_HI);
   assign head_now = enable & snake_head_active;

   // Current pixel is OR'ed in so a hit on the frame_end cycle still counts.
   assign body_hit  = body_q  | (head_now & snake_body_active);
   assign wall_hit  = wall_q  | (head_now & in_wall);
   assign apple_hit = apple_q | (head_now & apple_active);

   // Accumulate hits during the frame; drop them once the frame is evaluated.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      body_d  = body_hit;
      wall_d  = wall_hit;
      apple_d = apple_hit;
      if (frame_end) begin
         body_d  = 1'b0;
         wall_d  = 1'b0;
         apple_d = 1'b0;
      end
   end

   // Sticky flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
      if (!rst_n) begin
         body_q  <= 1'b0;
         wall_q  <= 1'b0;
         apple_q <= 1'b0;
      end else begin
         body_q  <= body_d;
         wall_q  <= wall_d;
         apple_q <= apple_d;
      end
   end

endmodule

// File: rtl/snake_game_fsm.sv
// Snake game controller: game state machine, step pacing, game-over hold
// timer and score. All outputs are registered.
module snake_game_fsm
   import snake_pkg::*;
#(
   parameter int BIT              = 10,
   parameter int H_RES            = H_RES_DEF,
   parameter int V_RES            = V_RES_DEF,
   parameter int BORDER           = BORDER_DEF,
   parameter int FRAMES_PER_STEP  = 8,
   parameter int OVER_HOLD_FRAMES = 60,
   parameter int SCORE_W          = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [BIT-1:0]     x_pos,
   input  logic [BIT-1:0]     y_pos,
   input  logic               frame_end,
   input  logic               snake_head_active,
   input  logic               snake_body_active,
   input  logic               apple_active,
   input  logic               start_btn,
   input  logic [2:0]         direction,
   output logic [1:0]         game_state,
   output logic               update,
   output logic               apple_eaten,
   output logic [SCORE_W-1:0] score
);

   localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int HOLD_W = $clog2(OVER_HOLD_FRAMES + 1);

   localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
   localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(OVER_HOLD_FRAMES);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   game_state_e        state_q, state_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               update_q, update_d;
   logic               apple_eaten_q, apple_eaten_d;
   logic               start_q, start_d;

   logic start_rise;
   logic body_hit, wall_hit, apple_hit;

   assign start_rise = start_btn & ~start_q;

   snake_hit_detect #(
      .BIT    (BIT),
      .H_RES  (H_RES),
      .V_RES  (V_RES),
      .BORDER (BORDER)
   ) u_hit (
      .clk               (clk),
      .rst_n             (rst_n),
      .x_pos             (x_pos),
      .y_pos             (y_pos),
      .frame_end         (frame_end),
      .enable            (state_q == ST_PLAY),
      .snake_head_active (snake_head_active),
      .snake_body_active (snake_body_active),
      .apple_active      (apple_active),
      .body_hit          (body_hit),
      .wall_hit          (wall_hit),
      .apple_hit         (apple_hit)
   );

   // Next-state, counters, score and output pulses.
   always_comb begin
      state_d       = state_q;
      step_d        = step_q;
      hold_d        = hold_q;
      score_d       = score_q;
      update_d      = 1'b0;
      apple_eaten_d = 1'b0;
      start_d       = start_btn;

      case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               state_d = ST_PLAY;
               score_d = '0;
               step_d  = '0;
            end
         end

         ST_PLAY: begin
            if (frame_end) begin
               if (body_hit | wall_hit) begin
                  // Collision wins over apple and step for this frame.
                  state_d = ST_OVER;
                  hold_d  = '0;
               end else begin
                  if (apple_hit) begin
                     apple_eaten_d = 1'b1;
                     if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
                  end
                  // Counter keeps pace even when stationary; only the pulse is gated.
                  if (step_q == STEP_LAST) begin
                     step_d   = '0;
                     update_d = (direction != DIR_IDLE);
                  end else begin
                     step_d = step_q + STEP_W'(1);
                  end
               end
            end
         end

         ST_OVER: begin
            if (frame_end && (hold_q != HOLD_MAX)) hold_d = hold_q + HOLD_W'(1);
            if (start_rise && (hold_q == HOLD_MAX)) begin
               state_d = ST_IDLE;
               hold_d  = '0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         step_q        <= '0;
         hold_q        <= '0;
         score_q       <= '0;
         update_q      <= 1'b0;
         apple_eaten_q <= 1'b0;
         start_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         hold_q        <= hold_d;
         score_q       <= score_d;
         update_q      <= update_d;
         apple_eaten_q <= apple_eaten_d;
         start_q       <= start_d;
      end
   end

   assign game_state  = state_q;
   assign update      = update_q;
   assign apple_eaten = apple_eaten_q;
   assign score       = score_q;

endmodule

// File: tb/tb_snake_game_fsm.sv
// Directed bench for snake_game_fsm with a scoreboard: stimulus queues the
// expected output event, a negedge monitor pops and compares whenever the DUT
// shows a pulse or a state change.
module tb_snake_game_fsm;
   import snake_pkg::*;

   localparam int FPS = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] x_pos, y_pos;
   logic       frame_end, head, body, apple, start_btn;
   logic [2:0] dir;
   logic [1:0] game_state;
   logic       update, apple_eaten;
   logic [7:0] score;

   typedef struct {
      int         cyc;
      logic [1:0] st;
      logic       upd;
      logic       eat;
      logic [7:0] score;
   } ev_t;

   ev_t        exp_q[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         exp_step = 0;
   logic [7:0] exp_score = 8'd0;
   logic [1:0] prev_state = 2'b00;

   snake_game_fsm dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .x_pos             (x_pos),
      .y_pos             (y_pos),
      .frame_end         (frame_end),
      .snake_head_active (head),
      .snake_body_active (body),
      .apple_active      (apple),
      .start_btn         (start_btn),
      .direction         (dir),
      .game_state        (game_state),
      .update            (update),
      .apple_eaten       (apple_eaten),
      .score             (score)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every pulse or state change must match the next queued event.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_state = 2'b00;
      end else begin
         if (update || apple_eaten || (game_state != prev_state)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: state=%0d update=%0b apple_eaten=%0b score=%0d at cycle %0d, none expected",
                        game_state, update, apple_eaten, score, cyc);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               check("event_cycle", cyc, e.cyc);
               check("event_state", game_state, e.st);
               check("event_update", update, e.upd);
               check("event_apple_eaten", apple_eaten, e.eat);
               check("event_score", score, e.score);
            end
         end
         prev_state = game_state;
      end
   end

   task automatic tick(input logic fe, input logic [9:0] x, input logic [9:0] y,
                       input logic h, input logic b, input logic a, input logic st);
      frame_end = fe; x_pos = x; y_pos = y;
      head = h; body = b; apple = a; start_btn = st;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tick(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Expected event appears one cycle after the inputs driven now.
   task automatic push_ev(input logic [1:0] st, input logic u, input logic e);
      exp_q.push_back('{cyc + 1, st, u, e, exp_score});
   endtask

   // One PLAY frame: an optional pixel (separate cycle or on the frame_end cycle).
   task automatic play_frame(input logic [9:0] x, input logic [9:0] y,
                             input logic h, input logic b, input logic a,
                             input logic same, input logic exp_over, input logic exp_eat);
      logic upd;
      if (!same) tick(1'b0, x, y, h, b, a, 1'b0);
      if (exp_over) begin
         push_ev(ST_OVER, 1'b0, 1'b0);
      end else begin
         upd = (exp_step == FPS - 1) && (dir != DIR_IDLE);
         exp_step = (exp_step == FPS - 1) ? 0 : exp_step + 1;
         if (exp_eat && exp_score != 8'hFF) exp_score = exp_score + 8'd1;
         if (upd || exp_eat) push_ev(ST_PLAY, upd, exp_eat);
      end
      if (same) tick(1'b1, x, y, h, b, a, 1'b0);
      else      tick(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
   endtask

   task automatic empty_frame();
      play_frame(10'd100, 10'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic over_frames(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         idle();
      end
   endtask

   task automatic start_press(input logic changes, input logic [1:0] new_st);
      if (changes) begin
         if (new_st == ST_PLAY) begin
            exp_score = 8'd0;
            exp_step  = 0;
         end
         push_ev(new_st, 1'b0, 1'b0);
      end
      tick(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      dir = DIR_RIGHT;
      frame_end = 0; x_pos = 0; y_pos = 0;
      head = 0; body = 0; apple = 0; start_btn = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", game_state, 2'b00);
      check("reset_update", update, 1'b0);
      check("reset_apple_eaten", apple_eaten, 1'b0);
      check("reset_score", score, 8'd0);
      rst_n = 1'b1;
      idle();

      // 1: start, then 8 moving frames -> one update after the 8th.
      start_press(1'b1, ST_PLAY);
      for (int i = 0; i < 8; i++) empty_frame();

      // 2: stationary for 16 frames, then UP: update on the 24th frame.
      dir = DIR_IDLE;
      for (int i = 0; i < 16; i++) empty_frame();
      dir = DIR_UP;
      for (int i = 0; i < 8; i++) empty_frame();

      // Wall boundaries that are still inside the playfield.
      play_frame(10'd5,   10'd5,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      play_frame(10'd634, 10'd474, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // 3: apple hits, score saturates at 255; one hit on the frame_end cycle itself.
      for (int i = 0; i < 256; i++)
         play_frame(10'd100, 10'd100, 1'b1, 1'b0, 1'b1, (i == 1), 1'b0, 1'b1);
      empty_frame();   // flags must have cleared: no apple_eaten here

      // 4: wall hit on a step frame -> GAME_OVER with no pulses.
      while (exp_step != FPS - 1) empty_frame();
      play_frame(10'd3, 10'd100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      over_frames(60);
      start_press(1'b1, ST_IDLE);   // score 255 held on the way out
      start_press(1'b1, ST_PLAY);

      // 5: head+body+apple together -> GAME_OVER, score unchanged; hold timing.
      play_frame(10'd100, 10'd100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      play_frame(10'd200, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      over_frames(10);
      start_press(1'b0, ST_OVER);
      over_frames(49);
      start_press(1'b0, ST_OVER);
      over_frames(1);
      start_press(1'b1, ST_IDLE);
      // Hits seen in IDLE must not be recorded.
      tick(1'b0, 10'd200, 10'd200, 1'b1, 1'b1, 1'b0, 1'b0);
      start_press(1'b1, ST_PLAY);
      empty_frame();

      // 6: async reset in GAME_OVER mid-frame.
      play_frame(10'd100, 10'd100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      play_frame(10'd300, 10'd475, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 10'd3, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_state", game_state, 2'b00);
      check("async_reset_score", score, 8'd0);
      check("async_reset_update", update, 1'b0);
      check("async_reset_apple_eaten", apple_eaten, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      idle();

      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/snake_game_fsm.md
Name: snake_game_fsm

Overview:
Game controller that sits directly downstream of the snake drawing stage and closes the loop back to it. Per pixel it consumes the head, body and apple "active" flags to detect collisions and apple hits during the scan. Once per frame it issues the step `update` pulse and drives the `game_state` bus that the drawing stage consumes. It also keeps the score.

Parameters:
BIT, 10, width of x_pos/y_pos pixel coordinates
H_RES, 640, visible horizontal pixels
V_RES, 480, visible vertical lines
BORDER, 5, wall thickness in pixels on every screen edge
FRAMES_PER_STEP, 8, frames between snake steps (>=1)
OVER_HOLD_FRAMES, 60, minimum frames in GAME_OVER before restart is accepted
SCORE_W, 8, score counter width

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
x_pos  in  BIT  current pixel column
y_pos  in  BIT  current pixel row
frame_end  in  1  one-cycle pulse once per frame, outside the visible area
snake_head_active  in  1  head covers current pixel
snake_body_active  in  1  body covers current pixel
apple_active  in  1  apple covers current pixel
start_btn  in  1  start button level, already synchronised to clk
direction  in  3  current direction code (IDLE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4)
game_state  out  2  IDLE=2'b00, PLAY=2'b01, GAME_OVER=2'b11
update  out  1  one-cycle step pulse to the drawing stage
apple_eaten  out  1  one-cycle pulse when an apple hit is accepted
score  out  SCORE_W  apples eaten this game

Behaviour:
- Reset (async, rst_n=0): game_state=IDLE, update=0, apple_eaten=0, score=0, all counters and flags 0, start edge register 0.
- Start edge: start_rise = start_btn & ~start_q; start_q is a register.
- Per-frame hit flags body_hit, wall_hit and apple_hit are sticky within a frame and set only in PLAY.
  - body_hit: head & body in the same cycle.
  - wall_hit: head & (x_pos<BORDER | x_pos>=H_RES-BORDER | y_pos<BORDER | y_pos>=V_RES-BORDER).
  - apple_hit: head & apple_active.
- A pixel sampled in the same cycle as frame_end is OR'ed in before evaluation.
- All three flags clear in the cycle after frame_end, regardless of state.
- FSM, all outputs registered; transitions take effect in the cycle after the triggering input:
  - IDLE:
    - start_rise -> PLAY, score cleared, step counter cleared.
  - PLAY, on frame_end:
    - If body_hit|wall_hit -> GAME_OVER; no update and no apple_eaten that frame. Collision has priority over apple.
    - Else if apple_hit: apple_eaten=1 for one cycle, score+1, saturating at all-ones.
    - Step counter: if it equals FRAMES_PER_STEP-1, wrap to 0 and assert update for one cycle, but only when direction!=IDLE. A stationary snake must not shift its body onto its head. Otherwise increment.
    - With direction==IDLE the counter still advances and wraps; only update is suppressed.
  - GAME_OVER:
    - Hold counter increments on each frame_end and saturates at OVER_HOLD_FRAMES.
    - start_rise while the counter is saturated -> IDLE, hold counter cleared.
    - start_rise earlier is ignored.
    - score is held, for display.
  - 2'b10 is illegal and recovers to IDLE next cycle.
- update and apple_eaten are never high outside PLAY, and never high in the cycle game_state changes to GAME_OVER.
- Arithmetic: wall compares are unsigned, BIT wide. Constants H_RES-BORDER and V_RES-BORDER are computed at elaboration.
- Reset mid-frame or mid-step discards all flags and counters; no pulse is emitted.

Decomposition:
- Shared package snake_pkg:
  - state encodings IDLE/PLAY/GAME_OVER
  - direction codes IDLE/UP/DOWN/LEFT/RIGHT
  - H_RES, V_RES, BORDER defaults
  - The drawing stage uses the same codes.
- One natural sub-module, snake_hit_detect: the per-pixel sticky flag logic, with inputs x/y/active flags/frame_end/enable and outputs body_hit/wall_hit/apple_hit.
- The FSM, step counter, hold counter and score stay in the top.

Test Plan:
1. Reset then start_btn 0->1 -> game_state=01 one cycle after the edge, score=0. Eight frame_end pulses with direction=RIGHT -> exactly one update, one cycle after the 8th frame_end.
2. PLAY, direction=IDLE for 16 frames -> update never asserted. Then direction=UP -> update on the 24th frame_end.
3. PLAY, one cycle with head=1, apple=1 at (100,100), then frame_end -> apple_eaten pulse, score 0->1. 256 such frames with SCORE_W=8 -> score stays at 255.
4. PLAY, head=1 at x_pos=3 (inside BORDER), then frame_end coinciding with a step -> game_state=11, update=0, apple_eaten=0.
5. Head & body & apple in the same frame -> GAME_OVER, score unchanged. start_rise after 10 frames is ignored. start_rise after 60 frames -> IDLE; a second start_rise -> PLAY with score=0.
6. rst_n low asynchronously in GAME_OVER mid-frame -> game_state=00 and score=0 immediately, with no update or apple_eaten glitch.
